// File: rtl/mul_int_pkg.sv
// Shared types and helpers for the shift-add multiply-accumulate unit.
// Holds the FSM state encoding and the iteration counter width function.
package mul_int_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } mul_state_e;

  // Counter must be able to hold WIDTH itself once the last iteration completes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_int.sv
// Sequential shift-add multiply-accumulate: p = a*b + c, one multiplier bit per clock.
// Operand and handshake layout lines up with the divider so q, y, r can be checked as a, b, c.
module mul_int
  import mul_int_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf,
  output mul_state_e         o_dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  // Handshake: start is taken only in IDLE (busy=0, valid may be 1); the accept edge
  // raises busy and clears valid/p/ovf; exactly WIDTH edges later busy falls and valid
  // rises with p/ovf, which then hold until the next accept or reset.

  mul_state_e      r_state;
  mul_state_e      w_next;
  logic [PW-1:0]   r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_valid;
  logic [PW-1:0]   r_p;
  logic            r_ovf;

  logic [WIDTH-1:0] w_b_shift;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_next;
  logic             w_last;
  logic             w_accept;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  // Operands stay put; the count selects the multiplier bit and the multiplicand shift.
  assign w_b_shift  = r_b >> r_cnt;
  assign w_addend   = w_b_shift[0] ? (r_a << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = CALC;
      CALC:    if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_p     <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= PW'(a);
      r_b     <= b;
      r_acc   <= PW'(c);
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
      r_p     <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
        r_p     <= w_acc_next;
        r_ovf   <= |w_acc_next[PW-1:WIDTH];
      end
    end
  end

  assign busy        = r_busy;
  assign valid       = r_valid;
  assign p           = r_p;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_int.sv
// Randomized bench for mul_int: operations are checked against a plain a*b+c model
// through an expected queue, along with latency, handshake and reset behaviour.
module tb_mul_int;
  import mul_int_pkg::*;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;
  localparam int W     = PW + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             valid;
  logic [PW-1:0]    p;
  logic             ovf;
  mul_state_e       dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  mul_int #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .c          (c),
    .busy       (busy),
    .valid      (valid),
    .p          (p),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: exact unsigned product-plus-addend, ovf when it needs more than WIDTH bits
  function automatic logic [W-1:0] model(input int unsigned ta, tb, tc);
    int unsigned  r;
    logic [W-1:0] v;
    r = ta * tb + tc;
    v = W'(r);
    v[W-1] = (r >= (32'd1 << WIDTH));
    return v;
  endfunction

  task automatic scramble_operands();
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = WIDTH'($urandom);
  endtask

  // driver: one accepted operation; with noise, start stays high and operands churn while busy
  task automatic run_op(input logic [WIDTH-1:0] ta, tb, tc, input bit noise);
    int           lat;
    int           busy_cycles;
    bit           overlap;
    logic [W-1:0] e;
    @(negedge clk);
    a = ta; b = tb; c = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_operands();
    exp_q.push_back(model(32'(ta), 32'(tb), 32'(tc)));
    check("accept_busy",  32'(busy),  32'd1);
    check("accept_valid", 32'(valid), 32'd0);
    check("accept_p",     32'(p),     32'd0);
    check("accept_state", 32'(dbg_state), 32'(CALC));
    lat = 0; busy_cycles = 0; overlap = 1'b0;
    while (!valid && lat < 3 * WIDTH) begin
      if (busy) busy_cycles++;
      if (noise) begin
        start = 1'b1;
        scramble_operands();
      end
      @(posedge clk); #1;
      lat++;
      if (busy && valid) overlap = 1'b1;
    end
    start = 1'b0;
    check("latency",     32'(lat),         32'(WIDTH));
    check("busy_cycles", 32'(busy_cycles), 32'(WIDTH));
    check("busy_valid_overlap", 32'(overlap), 32'd0);
    check("done_busy",   32'(busy),        32'd0);
    e = exp_q.pop_front();
    check("p",   32'(p),   32'(e[PW-1:0]));
    check("ovf", 32'(ovf), 32'(e[W-1]));
  endtask

  // reset two cycles into an operation: outputs clear at once, no valid afterwards
  task automatic abort_op();
    int valid_seen;
    @(negedge clk);
    a = 4'd7; b = 4'd7; c = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_valid", 32'(valid),     32'd0);
    check("abort_p",     32'(p),         32'd0);
    check("abort_ovf",   32'(ovf),       32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(posedge clk); #1;
      if (valid || busy) valid_seen++;
    end
    check("abort_no_valid", 32'(valid_seen), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
    #3;
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_valid", 32'(valid),     32'd0);
    check("rst_p",     32'(p),         32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    // first edge after release accepts
    run_op(4'd0,  4'd2,  4'd0,  1'b0);
    run_op(4'd3,  4'd2,  4'd1,  1'b0);
    run_op(4'd5,  4'd3,  4'd0,  1'b0);
    run_op(4'd15, 4'd15, 4'd15, 1'b0);
    // start held and operands churned while busy must be ignored
    run_op(4'd3,  4'd3,  4'd0,  1'b1);
    // back-to-back while valid is high
    run_op(4'd2,  4'd2,  4'd0,  1'b0);
    check("b2b_pre_valid", 32'(valid), 32'd1);
    run_op(4'd4,  4'd4,  4'd0,  1'b0);
    abort_op();
    run_op(4'd1,  4'd1,  4'd0,  1'b0);
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    run_op(4'd15, 4'd15, 4'd0, 1'b0);
    run_op(4'd1,  4'd15, 4'd0, 1'b0);
    run_op(4'd0,  4'd0,  4'd15, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
